cache_nway: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate cache: datapath plus controller FSM.

---
 rtl/cache_types_pkg.sv | 52 +++++
 rtl/plru_tree.sv | 59 +++++
 rtl/cache_nway.sv | 155 +++++++++++++++
 tb/tb_cache_nway.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types_pkg.sv
// Shared types and helpers for the N-way set-associative cache:
// controller state encoding, width helpers, address field extraction
// and byte-enable to line-mask expansion.
package cache_types_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    // Widest line the mask helper supports (s_offset up to 7).
    localparam int MAX_LINE = 1024;

    function automatic int calc_s_line(input int s_offset);
        return 8 * (2 ** s_offset);
    endfunction

    function automatic int calc_s_tag(input int s_offset, input int s_index);
        return 32 - s_offset - s_index;
    endfunction

    function automatic int calc_s_way(input int num_ways);
        return $clog2(num_ways);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int s_offset,
                                             input int s_index);
        return addr >> (s_offset + s_index);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int s_offset,
                                               input int s_index);
        return (addr >> s_offset) & ((32'd1 << s_index) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_word(input logic [31:0] addr, input int s_offset);
        return (addr >> 2) & ((32'd1 << (s_offset - 2)) - 32'd1);
    endfunction

    // Expand 4 byte enables of the selected word into a full-line bit mask.
    function automatic logic [MAX_LINE-1:0] be_line_mask(input logic [3:0] be, input int word_sel);
        logic [MAX_LINE-1:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) m[word_sel*32 + b*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU state for every set. Bits are heap-ordered (node 0 is
// the root, children 2n+1 / 2n+2); a 0 bit means the victim lies in the
// left subtree. A touch points every node on the way's path away from it.
module plru_tree
    import cache_types_pkg::*;
#(
    parameter int num_ways = 4,
    parameter int s_index  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [s_index-1:0]          index,
    input  logic                        touch,
    input  logic [$clog2(num_ways)-1:0] touch_way,
    output logic [$clog2(num_ways)-1:0] victim_way
);
    localparam int s_way    = calc_s_way(num_ways);
    localparam int num_sets = 2 ** s_index;

    logic [num_sets-1:0][num_ways-2:0] bits;
    logic [num_ways-2:0]               row;
    logic [num_ways-2:0]               row_next;

    assign row = bits[index];

    // Walk from the root following the stored bits to find the victim leaf.
    always_comb begin
        int node;
        node = 0;
        for (int l = 0; l < s_way; l++) begin
            node = 2 * node + 1 + int'(row[node]);
        end
        victim_way = s_way'(node - (num_ways - 1));
    end

    // Point every node on the touched way's path away from that way.
    always_comb begin
        int   node;
        logic dir;
        row_next = row;
        node     = 0;
        dir      = 1'b0;
        for (int l = 0; l < s_way; l++) begin
            dir            = touch_way[s_way-1-l];
            row_next[node] = ~dir;
            node           = 2 * node + 1 + int'(dir);
        end
    end

    // PLRU storage; cleared on reset, updated on each completed hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bits <= '0;
        end else if (touch) begin
            bits[index] <= row_next;
        end
    end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative, write-back, write-allocate cache: tag/data
// arrays, hit detection, byte-merged write hits, victim selection
// (lowest invalid way, else tree-PLRU) and the line fill / writeback FSM.
module cache_nway
    import cache_types_pkg::*;
#(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int num_ways = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_read,
    input  logic                        mem_write,
    input  logic [31:0]                 mem_address,
    input  logic [31:0]                 mem_wdata,
    input  logic [3:0]                  mem_byte_enable,
    output logic [31:0]                 mem_rdata,
    output logic                        mem_resp,
    output logic                        pmem_read,
    output logic                        pmem_write,
    output logic [31:0]                 pmem_address,
    output logic [(8<<s_offset)-1:0]    pmem_wdata,
    input  logic [(8<<s_offset)-1:0]    pmem_rdata,
    input  logic                        pmem_resp
);
    localparam int s_line   = calc_s_line(s_offset);
    localparam int s_tag    = calc_s_tag(s_offset, s_index);
    localparam int s_way    = calc_s_way(num_ways);
    localparam int s_word   = s_offset - 2;
    localparam int num_sets = 2 ** s_index;

    state_t state, state_next;

    logic [s_tag-1:0]  tag_arr  [num_ways][num_sets];
    logic [s_line-1:0] data_arr [num_ways][num_sets];
    logic [num_sets-1:0][num_ways-1:0] valid_arr;
    logic [num_sets-1:0][num_ways-1:0] dirty_arr;

    logic [s_index-1:0]  idx_r;
    logic [s_way-1:0]    victim_r;
    logic [s_tag-1:0]    req_tag;
    logic [s_index-1:0]  req_idx;
    logic [s_word-1:0]   req_word;
    logic [s_line-1:0]   wr_mask;
    logic                req_any;

    logic [num_ways-1:0] hit;
    logic                hit_any;
    logic [s_way-1:0]    hit_way;
    logic [s_line-1:0]   hit_line;
    logic                inv_found;
    logic [s_way-1:0]    inv_way;
    logic [s_way-1:0]    plru_way;
    logic [s_way-1:0]    miss_way;
    logic                miss_dirty;

    assign req_tag  = s_tag'(addr_tag(mem_address, s_offset, s_index));
    assign req_idx  = s_index'(addr_index(mem_address, s_offset, s_index));
    assign req_word = s_word'(addr_word(mem_address, s_offset));
    assign wr_mask  = s_line'(be_line_mask(mem_byte_enable, int'(req_word)));
    assign req_any  = mem_read | mem_write;

    // Tag compare across ways plus lowest-invalid-way search for victims.
    always_comb begin
        hit       = '0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < num_ways; w++) begin
            hit[w] = valid_arr[idx_r][w] && (tag_arr[w][idx_r] == req_tag);
            if (hit[w]) hit_way = s_way'(w);
        end
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (!valid_arr[idx_r][w]) begin
                inv_found = 1'b1;
                inv_way   = s_way'(w);
            end
        end
    end

    assign hit_any    = |hit;
    assign hit_line   = data_arr[hit_way][idx_r];
    assign miss_way   = inv_found ? inv_way : plru_way;
    assign miss_dirty = valid_arr[idx_r][miss_way] & dirty_arr[idx_r][miss_way];

    assign mem_resp   = (state == CHECK) && req_any && hit_any;
    assign mem_rdata  = hit_line[{req_word, 5'd0} +: 32];
    assign pmem_read  = (state == ALLOCATE);
    assign pmem_write = (state == WRITEBACK);
    assign pmem_wdata = data_arr[victim_r][idx_r];
    assign pmem_address = (state == WRITEBACK)
                        ? {tag_arr[victim_r][idx_r], idx_r, {s_offset{1'b0}}}
                        : {req_tag, idx_r, {s_offset{1'b0}}};

    plru_tree #(.num_ways(num_ways), .s_index(s_index)) u_plru (
        .clk        (clk),
        .rst        (rst),
        .index      (idx_r),
        .touch      (mem_resp),
        .touch_way  (hit_way),
        .victim_way (plru_way)
    );

    // Controller next-state: lookup, optional dirty writeback, then fill and re-check.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (req_any) state_next = CHECK;
            CHECK: begin
                if (!req_any || hit_any) state_next = IDLE;
                else if (miss_dirty)     state_next = WRITEBACK;
                else                     state_next = ALLOCATE;
            end
            WRITEBACK: if (pmem_resp) state_next = ALLOCATE;
            ALLOCATE:  if (pmem_resp) state_next = CHECK;
            default:   state_next = IDLE;
        endcase
    end

    // Control state: FSM, valid and dirty bits (reset clears all lines).
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid_arr <= '0;
            dirty_arr <= '0;
        end else begin
            state <= state_next;
            if (mem_resp && mem_write) dirty_arr[idx_r][hit_way] <= 1'b1;
            if (state == ALLOCATE && pmem_resp) begin
                valid_arr[idx_r][victim_r] <= 1'b1;
                dirty_arr[idx_r][victim_r] <= 1'b0;
            end
        end
    end

    // Capture set index at request acceptance and the victim chosen on a miss.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_any) idx_r <= req_idx;
        if (state == CHECK && !hit_any) victim_r <= miss_way;
    end

    // Data and tag storage: byte-merged write hits and line fills.
    always_ff @(posedge clk) begin
        if (mem_resp && mem_write) begin
            data_arr[hit_way][idx_r] <= (hit_line & ~wr_mask)
                                      | ({(s_line/32){mem_wdata}} & wr_mask);
        end
        if (state == ALLOCATE && pmem_resp) begin
            data_arr[victim_r][idx_r] <= pmem_rdata;
            tag_arr[victim_r][idx_r]  <= req_tag;
        end
    end

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway (4 ways, 8 sets, 32-byte lines). A simple
// memory responder answers line requests after two cycles with a fixed
// pattern: word at byte address X reads 0xC0DE_0000 | X[15:0].
module tb_cache_nway;
    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address, mem_wdata, mem_rdata;
    logic [3:0]   mem_byte_enable;
    logic         mem_resp;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] w0;
        logic [31:0] w1;
    } pev_t;

    pev_t plog[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cache_nway #(.s_offset(5), .s_index(3), .num_ways(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    assert property (@(posedge clk) disable iff (rst) !(pmem_read && pmem_write));
    assert property (@(posedge clk) disable iff (rst) (mem_read && !mem_resp) |=> mem_read);
    assert property (@(posedge clk) disable iff (rst) (mem_write && !mem_resp) |=> mem_write);

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] line_pattern(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  x;
        for (int i = 0; i < 8; i++) begin
            x = a + 32'(4 * i);
            l[i*32 +: 32] = 32'hC0DE_0000 | {16'h0, x[15:0]};
        end
        return l;
    endfunction

    // Memory responder: logs each new line request, answers after two cycles.
    initial begin
        int   cnt;
        pev_t ev;
        cnt        = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                cnt       = 0;
            end else if (pmem_read || pmem_write) begin
                if (cnt == 0) begin
                    ev.wr   = pmem_write;
                    ev.addr = pmem_address;
                    ev.w0   = pmem_wdata[31:0];
                    ev.w1   = pmem_wdata[63:32];
                    plog.push_back(ev);
                end
                cnt++;
                if (cnt == 2) begin
                    pmem_rdata = line_pattern(pmem_address);
                    pmem_resp  = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic get_ev(input int i, output pev_t ev);
        if (i < plog.size()) begin
            ev = plog[i];
        end else begin
            ev.wr   = 1'bx;
            ev.addr = 'x;
            ev.w0   = 'x;
            ev.w1   = 'x;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output int cyc);
        @(negedge clk);
        plog.delete();
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wdata;
        mem_byte_enable = be;
        cyc = 0;
        while (!mem_resp && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check32({tag, " resp"}, {31'd0, mem_resp}, 32'd1);
        rdata = mem_rdata;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic expect_one(input string tag, input logic wr, input logic [31:0] addr);
        pev_t ev;
        check32({tag, " pmem count"}, 32'(plog.size()), 32'd1);
        get_ev(0, ev);
        check32({tag, " pmem kind"}, {31'd0, ev.wr}, {31'd0, wr});
        check32({tag, " pmem addr"}, ev.addr, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          cyc;
        pev_t        ev;

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;

        do_reset();
        check32("reset mem_resp", {31'd0, mem_resp}, 32'd0);
        check32("reset pmem_read", {31'd0, pmem_read}, 32'd0);
        check32("reset pmem_write", {31'd0, pmem_write}, 32'd0);

        // 1: cold miss fill
        access("t1", 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, rd, cyc);
        expect_one("t1", 1'b0, 32'h0000_1000);
        check32("t1 rdata", rd, 32'hC0DE_1000);

        // 2: hit on same line
        access("t2", 1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0, rd, cyc);
        check32("t2 latency", 32'(cyc), 32'd1);
        check32("t2 pmem count", 32'(plog.size()), 32'd0);
        check32("t2 rdata", rd, 32'hC0DE_1004);

        // 3: partial write hit, then read back
        access("t3w", 1'b0, 1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 4'b0011, rd, cyc);
        check32("t3w latency", 32'(cyc), 32'd1);
        check32("t3w pmem count", 32'(plog.size()), 32'd0);
        access("t3r", 1'b1, 1'b0, 32'h0000_1008, 32'h0, 4'h0, rd, cyc);
        check32("t3r rdata", rd, 32'hC0DE_BEEF);

        // read and write together: write wins, pre-merge word returned
        access("rw", 1'b1, 1'b1, 32'h0000_100C, 32'hAABB_CCDD, 4'b1100, rd, cyc);
        check32("rw premerge", rd, 32'hC0DE_100C);
        access("rwr", 1'b1, 1'b0, 32'h0000_100C, 32'h0, 4'h0, rd, cyc);
        check32("rwr rdata", rd, 32'hAABB_100C);

        // 4: fill set 0 then evict PLRU way 0
        do_reset();
        access("t4a", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, rd, cyc);
        expect_one("t4a", 1'b0, 32'h0000_0100);
        access("t4b", 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, rd, cyc);
        expect_one("t4b", 1'b0, 32'h0000_0200);
        access("t4c", 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, rd, cyc);
        expect_one("t4c", 1'b0, 32'h0000_0300);
        access("t4d", 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0, rd, cyc);
        expect_one("t4d", 1'b0, 32'h0000_0400);
        access("t4e", 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'h0, rd, cyc);
        expect_one("t4e", 1'b0, 32'h0000_0500);
        check32("t4e rdata", rd, 32'hC0DE_0500);
        access("t4f", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, rd, cyc);
        expect_one("t4f", 1'b0, 32'h0000_0100);
        access("t4g", 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, rd, cyc);
        check32("t4g latency", 32'(cyc), 32'd1);
        check32("t4g pmem count", 32'(plog.size()), 32'd0);
        check32("t4g rdata", rd, 32'hC0DE_0200);

        // 5: dirty victim written back before the fill
        do_reset();
        access("t5w", 1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'hF, rd, cyc);
        expect_one("t5w", 1'b0, 32'h0000_0100);
        access("t5a", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, rd, cyc);
        check32("t5a rdata", rd, 32'h1234_5678);
        check32("t5a latency", 32'(cyc), 32'd1);
        access("t5b", 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, rd, cyc);
        access("t5c", 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, rd, cyc);
        access("t5d", 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0, rd, cyc);
        access("t5e", 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'h0, rd, cyc);
        check32("t5e pmem count", 32'(plog.size()), 32'd2);
        get_ev(0, ev);
        check32("t5e first kind", {31'd0, ev.wr}, 32'd1);
        check32("t5e wb addr", ev.addr, 32'h0000_0100);
        check32("t5e wb word0", ev.w0, 32'h1234_5678);
        check32("t5e wb word1", ev.w1, 32'hC0DE_0104);
        get_ev(1, ev);
        check32("t5e second kind", {31'd0, ev.wr}, 32'd0);
        check32("t5e fill addr", ev.addr, 32'h0000_0500);
        check32("t5e rdata", rd, 32'hC0DE_0500);

        // 6: reset during writeback
        do_reset();
        access("t6w", 1'b0, 1'b1, 32'h0000_1000, 32'h0BAD_F00D, 4'hF, rd, cyc);
        access("t6a", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, rd, cyc);
        access("t6b", 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, rd, cyc);
        access("t6c", 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, rd, cyc);
        @(negedge clk);
        mem_read    = 1'b1;
        mem_address = 32'h0000_0400;
        cyc = 0;
        while (!pmem_write && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check32("t6 wb seen", {31'd0, pmem_write}, 32'd1);
        check32("t6 wb addr", pmem_address, 32'h0000_1000);
        rst      = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        check32("t6 rst pmem_write", {31'd0, pmem_write}, 32'd0);
        check32("t6 rst pmem_read", {31'd0, pmem_read}, 32'd0);
        check32("t6 rst mem_resp", {31'd0, mem_resp}, 32'd0);
        rst = 1'b0;
        access("t6r", 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, rd, cyc);
        expect_one("t6r", 1'b0, 32'h0000_1000);
        check32("t6r rdata", rd, 32'hC0DE_1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
